// File: rtl/pc_sel_chk_mon_if.sv
// ---------------------------------------------------------------------------
// pc_sel_chk_mon_if : F-stage fetch bundle watched by the PC-select checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pc_sel_chk_mon_if #(
   parameter int NTHR = 4,
   parameter int PCW  = 48
);
   logic                 inst_vld_f;
   logic                 dtu_fcl_running_s;
   logic [NTHR-1:0]      thr_f;
   logic [PCW-1:0]       pc_f;
   logic [NTHR*PCW-1:0]  tpc_f;

   modport master (
      output inst_vld_f,
      output dtu_fcl_running_s,
      output thr_f,
      output pc_f,
      output tpc_f
   );

   modport slave (
      input inst_vld_f,
      input dtu_fcl_running_s,
      input thr_f,
      input pc_f,
      input tpc_f
   );
endinterface

`default_nettype wire

// File: rtl/pc_sel_chk_mon.sv
// ---------------------------------------------------------------------------
// pc_sel_chk_mon : two-stage checker that the F-stage PC matches the selected
//                  thread's PC register; first-failure capture and counters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sel_chk_mon #(
   parameter int NTHR       = 4,
   parameter int PCW        = 48,
   parameter int CMP_LSB    = 0,
   parameter int CNTW       = 16,
   parameter int ONEHOT_CHK = 1,
   parameter int TW         = $clog2(NTHR)
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            enable,
   input  wire logic [2:0]      coreid,
   pc_sel_chk_mon_if.slave      f_if,
   input  wire logic            clr_err,
   output logic                 fail_pulse,
   output logic                 err_sticky,
   output logic                 err_onehot,
   output logic [TW-1:0]        fail_thr,
   output logic [PCW-1:0]       fail_pc,
   output logic [PCW-1:0]       fail_exp,
   output logic [CNTW-1:0]      chk_cnt,
   output logic [CNTW-1:0]      mis_cnt
);

   localparam logic [PCW-1:0]  CMP_MASK = {PCW{1'b1}} << CMP_LSB;
   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic            OH_EN    = (ONEHOT_CHK != 0);

   // S1 sample registers
   logic            s1_vld_q, s1_vld_d;
   logic [NTHR-1:0] s1_thr_q, s1_thr_d;
   logic [TW-1:0]   s1_sel_q, s1_sel_d;
   logic [PCW-1:0]  s1_pc_q,  s1_pc_d;
   logic [PCW-1:0]  s1_exp_q, s1_exp_d;

   // Result registers
   logic            fail_pulse_q, fail_pulse_d;
   logic            err_sticky_q, err_sticky_d;
   logic            err_onehot_q, err_onehot_d;
   logic [TW-1:0]   fail_thr_q,   fail_thr_d;
   logic [PCW-1:0]  fail_pc_q,    fail_pc_d;
   logic [PCW-1:0]  fail_exp_q,   fail_exp_d;
   logic [CNTW-1:0] chk_cnt_q,    chk_cnt_d;
   logic [CNTW-1:0] mis_cnt_q,    mis_cnt_d;

   logic            qual;
   logic            any_sel;
   logic [TW-1:0]   sel;
   logic            mis;
   logic            oh;
   logic            err;
   logic            cap_load;

   always_comb begin
      sel     = '0;
      any_sel = 1'b0;
      // Scan downward so the lowest set bit is the one left standing.
      for (int t = NTHR - 1; t >= 0; t--) begin
         if (f_if.thr_f[t]) begin
            sel     = TW'(t);
            any_sel = 1'b1;
         end
      end

      qual = enable & f_if.inst_vld_f & f_if.dtu_fcl_running_s;

      s1_vld_d = qual & (any_sel | OH_EN);
      s1_thr_d = s1_thr_q;
      s1_sel_d = s1_sel_q;
      s1_pc_d  = s1_pc_q;
      s1_exp_d = s1_exp_q;
      if (qual) begin
         s1_thr_d = f_if.thr_f;
         s1_sel_d = sel;
         s1_pc_d  = f_if.pc_f;
         s1_exp_d = any_sel ? f_if.tpc_f[int'(sel)*PCW +: PCW] : '0;
      end
   end

   always_comb begin
      // An empty thread select has no expected PC, so it can only be a one-hot error.
      mis = s1_vld_q & (|s1_thr_q) & ((s1_pc_q & CMP_MASK) != (s1_exp_q & CMP_MASK));
      oh  = s1_vld_q & OH_EN & ($countones(s1_thr_q) != 1);
      err = mis | oh;

      fail_pulse_d = err;

      chk_cnt_d = chk_cnt_q;
      if (s1_vld_q && (chk_cnt_q != CNT_MAX)) begin
         chk_cnt_d = chk_cnt_q + CNT_ONE;
      end
      mis_cnt_d = mis_cnt_q;
      if (err && (mis_cnt_q != CNT_MAX)) begin
         mis_cnt_d = mis_cnt_q + CNT_ONE;
      end

      // A clear coinciding with a new error re-arms capture and keeps the new error.
      cap_load = err & (clr_err | ~(err_sticky_q | err_onehot_q));

      if (clr_err) begin
         err_sticky_d = mis;
         err_onehot_d = oh;
      end else begin
         err_sticky_d = err_sticky_q | mis;
         err_onehot_d = err_onehot_q | oh;
      end

      fail_thr_d = fail_thr_q;
      fail_pc_d  = fail_pc_q;
      fail_exp_d = fail_exp_q;
      if (cap_load) begin
         fail_thr_d = s1_sel_q;
         fail_pc_d  = s1_pc_q;
         fail_exp_d = s1_exp_q;
      end else if (clr_err) begin
         fail_thr_d = '0;
         fail_pc_d  = '0;
         fail_exp_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q     <= 1'b0;
         s1_thr_q     <= '0;
         s1_sel_q     <= '0;
         s1_pc_q      <= '0;
         s1_exp_q     <= '0;
         fail_pulse_q <= 1'b0;
         err_sticky_q <= 1'b0;
         err_onehot_q <= 1'b0;
         fail_thr_q   <= '0;
         fail_pc_q    <= '0;
         fail_exp_q   <= '0;
         chk_cnt_q    <= '0;
         mis_cnt_q    <= '0;
      end else begin
         s1_vld_q     <= s1_vld_d;
         s1_thr_q     <= s1_thr_d;
         s1_sel_q     <= s1_sel_d;
         s1_pc_q      <= s1_pc_d;
         s1_exp_q     <= s1_exp_d;
         fail_pulse_q <= fail_pulse_d;
         err_sticky_q <= err_sticky_d;
         err_onehot_q <= err_onehot_d;
         fail_thr_q   <= fail_thr_d;
         fail_pc_q    <= fail_pc_d;
         fail_exp_q   <= fail_exp_d;
         chk_cnt_q    <= chk_cnt_d;
         mis_cnt_q    <= mis_cnt_d;
      end
   end

   assign fail_pulse = fail_pulse_q;
   assign err_sticky = err_sticky_q;
   assign err_onehot = err_onehot_q;
   assign fail_thr   = fail_thr_q;
   assign fail_pc    = fail_pc_q;
   assign fail_exp   = fail_exp_q;
   assign chk_cnt    = chk_cnt_q;
   assign mis_cnt    = mis_cnt_q;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && err) begin
         $display("%0t pc_sel_chk_mon core %0d: wrong PC selected for thread %0d, pc_f=%h expected=%h",
                  $time, coreid, s1_sel_q, s1_pc_q, s1_exp_q);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sel_chk_mon.sv
// ---------------------------------------------------------------------------
// tb_pc_sel_chk_mon : two checker configurations driven from one fetch bundle,
//                     compared every cycle against a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_sel_chk_mon;

   localparam int NTHR = 4;
   localparam int PCW  = 48;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       clr_err;
   logic [2:0] coreid = 3'd1;

   pc_sel_chk_mon_if #(.NTHR(NTHR), .PCW(PCW)) f_if ();

   logic          fail_pulse_a, err_sticky_a, err_onehot_a;
   logic [1:0]    fail_thr_a;
   logic [47:0]   fail_pc_a, fail_exp_a;
   logic [15:0]   chk_cnt_a, mis_cnt_a;
   logic          fail_pulse_b, err_sticky_b, err_onehot_b;
   logic [1:0]    fail_thr_b;
   logic [47:0]   fail_pc_b, fail_exp_b;
   logic [3:0]    chk_cnt_b, mis_cnt_b;

   pc_sel_chk_mon #(.NTHR(NTHR), .PCW(PCW), .CMP_LSB(0), .CNTW(16), .ONEHOT_CHK(1)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .coreid(coreid), .f_if(f_if), .clr_err(clr_err),
      .fail_pulse(fail_pulse_a), .err_sticky(err_sticky_a), .err_onehot(err_onehot_a),
      .fail_thr(fail_thr_a), .fail_pc(fail_pc_a), .fail_exp(fail_exp_a),
      .chk_cnt(chk_cnt_a), .mis_cnt(mis_cnt_a)
   );

   pc_sel_chk_mon #(.NTHR(NTHR), .PCW(PCW), .CMP_LSB(2), .CNTW(4), .ONEHOT_CHK(0)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .coreid(coreid), .f_if(f_if), .clr_err(clr_err),
      .fail_pulse(fail_pulse_b), .err_sticky(err_sticky_b), .err_onehot(err_onehot_b),
      .fail_thr(fail_thr_b), .fail_pc(fail_pc_b), .fail_exp(fail_exp_b),
      .chk_cnt(chk_cnt_b), .mis_cnt(mis_cnt_b)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Per-configuration settings: index 0 is dut_a, index 1 is dut_b
   int cfg_onehot [2] = '{1, 0};
   int cfg_lsb    [2] = '{0, 2};
   int cfg_cmax   [2] = '{65535, 15};

   logic [47:0] tpc [NTHR];

   // Model state: visible results plus the one sample in flight
   logic        m_pulse [2], m_sticky [2], m_onehot [2];
   int          m_thr [2], m_chk [2], m_mis [2];
   logic [47:0] m_pc [2], m_exp [2];
   logic        p_vld [2], p_mis [2], p_oh [2];
   int          p_thr [2];
   logic [47:0] p_pc [2], p_exp [2];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_pulse[c] = 0; m_sticky[c] = 0; m_onehot[c] = 0;
         m_thr[c] = 0; m_chk[c] = 0; m_mis[c] = 0; m_pc[c] = '0; m_exp[c] = '0;
         p_vld[c] = 0; p_mis[c] = 0; p_oh[c] = 0; p_thr[c] = 0; p_pc[c] = '0; p_exp[c] = '0;
      end
   endtask

   // Advance the model by one clock: retire the pending sample, then take the new one.
   task automatic model_step();
      logic err;
      int   nset, low;
      nset = $countones(f_if.thr_f);
      low  = 0;
      for (int t = 0; t < NTHR; t++) begin
         if (f_if.thr_f[t] && low == 0 && f_if.thr_f[low] == 1'b0) low = t;
      end
      for (int c = 0; c < 2; c++) begin
         err = p_vld[c] && (p_mis[c] || p_oh[c]);
         m_pulse[c] = err;
         if (p_vld[c] && m_chk[c] < cfg_cmax[c]) m_chk[c]++;
         if (err && m_mis[c] < cfg_cmax[c]) m_mis[c]++;
         if (clr_err) begin
            m_sticky[c] = p_mis[c];
            m_onehot[c] = p_oh[c];
            m_thr[c] = err ? p_thr[c] : 0;
            m_pc[c]  = err ? p_pc[c]  : '0;
            m_exp[c] = err ? p_exp[c] : '0;
         end else begin
            if (err && !m_sticky[c] && !m_onehot[c]) begin
               m_thr[c] = p_thr[c]; m_pc[c] = p_pc[c]; m_exp[c] = p_exp[c];
            end
            m_sticky[c] = m_sticky[c] | p_mis[c];
            m_onehot[c] = m_onehot[c] | p_oh[c];
         end

         if (!(enable && f_if.inst_vld_f && f_if.dtu_fcl_running_s) ||
             (nset == 0 && cfg_onehot[c] == 0)) begin
            p_vld[c] = 0; p_mis[c] = 0; p_oh[c] = 0;
         end else begin
            p_vld[c] = 1;
            p_thr[c] = (nset == 0) ? 0 : low;
            p_pc[c]  = f_if.pc_f;
            p_exp[c] = (nset == 0) ? 48'h0 : tpc[low];
            p_oh[c]  = (cfg_onehot[c] != 0) && (nset != 1);
            p_mis[c] = (nset != 0) && ((f_if.pc_f >> cfg_lsb[c]) != (p_exp[c] >> cfg_lsb[c]));
         end
      end
   endtask

   task automatic compare_all();
      check_val("a_pulse",  fail_pulse_a, m_pulse[0]);
      check_val("a_sticky", err_sticky_a, m_sticky[0]);
      check_val("a_onehot", err_onehot_a, m_onehot[0]);
      check_val("a_thr",    fail_thr_a,   m_thr[0]);
      check_val("a_pc",     fail_pc_a,    m_pc[0]);
      check_val("a_exp",    fail_exp_a,   m_exp[0]);
      check_val("a_chk",    chk_cnt_a,    m_chk[0]);
      check_val("a_mis",    mis_cnt_a,    m_mis[0]);
      check_val("b_pulse",  fail_pulse_b, m_pulse[1]);
      check_val("b_sticky", err_sticky_b, m_sticky[1]);
      check_val("b_onehot", err_onehot_b, m_onehot[1]);
      check_val("b_thr",    fail_thr_b,   m_thr[1]);
      check_val("b_pc",     fail_pc_b,    m_pc[1]);
      check_val("b_exp",    fail_exp_b,   m_exp[1]);
      check_val("b_chk",    chk_cnt_b,    m_chk[1]);
      check_val("b_mis",    mis_cnt_b,    m_mis[1]);
   endtask

   // One clock of stimulus, applied and checked on the falling edge.
   task automatic drive(input logic en, input logic vld, input logic run,
                        input logic [3:0] thr, input logic [47:0] pc, input logic clr);
      enable = en;
      f_if.inst_vld_f = vld;
      f_if.dtu_fcl_running_s = run;
      f_if.thr_f = thr;
      f_if.pc_f  = pc;
      for (int t = 0; t < NTHR; t++) f_if.tpc_f[t*PCW +: PCW] = tpc[t];
      clr_err = clr;
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input logic clr);
      drive(1'b1, 1'b0, 1'b1, 4'b0000, 48'h0, clr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  thr;
      logic [47:0] pc;
      int          low;

      rst = 1'b1; enable = 1'b0; clr_err = 1'b0;
      f_if.inst_vld_f = 1'b0; f_if.dtu_fcl_running_s = 1'b0;
      f_if.thr_f = '0; f_if.pc_f = '0; f_if.tpc_f = '0;
      for (int t = 0; t < NTHR; t++) tpc[t] = '0;
      model_reset();
      @(negedge clk);
      compare_all();
      @(negedge clk);
      rst = 1'b0;

      // Matching T1 fetches, 100 cycles
      tpc[1] = 48'h0000_0040_1000;
      repeat (100) drive(1, 1, 1, 4'b0010, tpc[1], 0);
      idle(0);
      check_val("t1_chk_cnt", chk_cnt_a, 100);
      check_val("t1_mis_cnt", mis_cnt_a, 0);
      check_val("t6_chk_sat", chk_cnt_b, 4'hF);

      // T2 mismatch, then a T3 mismatch that must not disturb the capture
      tpc[2] = 48'h1008;
      drive(1, 1, 1, 4'b0100, 48'h1004, 0);
      check_val("t2_no_early_pulse", fail_pulse_a, 0);
      idle(0);
      check_val("t2_pulse",  fail_pulse_a, 1);
      check_val("t2_sticky", err_sticky_a, 1);
      check_val("t2_thr",    fail_thr_a, 2);
      check_val("t2_pc",     fail_pc_a, 48'h1004);
      check_val("t2_exp",    fail_exp_a, 48'h1008);
      tpc[3] = 48'h2000;
      drive(1, 1, 1, 4'b1000, 48'h3000, 0);
      idle(0);
      check_val("t2_mis_cnt2", mis_cnt_a, 2);
      check_val("t2_thr_held", fail_thr_a, 2);
      check_val("t2_pc_held",  fail_pc_a, 48'h1004);

      // clr_err alone
      idle(1);
      check_val("t5_clr_sticky", err_sticky_a, 0);
      check_val("t5_clr_pc",     fail_pc_a, 0);
      check_val("t5_clr_cnt",    mis_cnt_a, 2);

      // Two threads selected, PC matches T1
      drive(1, 1, 1, 4'b0110, tpc[1], 0);
      idle(0);
      check_val("t3_onehot",   err_onehot_a, 1);
      check_val("t3_sticky",   err_sticky_a, 0);
      check_val("t3_mis_cnt",  mis_cnt_a, 3);
      check_val("t3_b_pulse",  fail_pulse_b, 0);
      check_val("t3_b_onehot", err_onehot_b, 0);

      // Low PC bits excluded in dut_b
      idle(1);
      tpc[0] = 48'h1000;
      drive(1, 1, 1, 4'b0001, 48'h1003, 0);
      idle(0);
      check_val("t4_b_nomis", fail_pulse_b, 0);
      check_val("t4_a_mis",   fail_pulse_a, 1);
      drive(1, 1, 1, 4'b0001, 48'h1004, 0);
      idle(0);
      check_val("t4_b_mis", fail_pulse_b, 1);

      // clr_err coinciding with a new T0 mismatch
      idle(1);
      drive(1, 1, 1, 4'b0100, 48'h1004, 0);
      idle(0);
      drive(1, 1, 1, 4'b0001, 48'h5000, 0);
      idle(1);
      check_val("t5_err_wins", err_sticky_a, 1);
      check_val("t5_cap_thr",  fail_thr_a, 0);
      check_val("t5_cap_pc",   fail_pc_a, 48'h5000);
      check_val("t5_cap_exp",  fail_exp_a, 48'h1000);

      // Reset between S1 and S2 of a mismatching sample
      drive(1, 1, 1, 4'b0001, 48'h7000, 0);
      rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      check_val("t6_rst_cnt", chk_cnt_a, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(0);
      check_val("t6_no_pulse", fail_pulse_a, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         for (int t = 0; t < NTHR; t++) tpc[t] = 48'({$urandom(), $urandom()});
         if ($urandom_range(0, 3) != 0) thr = 4'(1 << $urandom_range(0, 3));
         else                           thr = 4'($urandom_range(0, 15));
         low = 0;
         for (int t = NTHR - 1; t >= 0; t--) if (thr[t]) low = t;
         pc = (thr == 0) ? 48'h0 : tpc[low];
         case ($urandom_range(0, 3))
            0: pc[$urandom_range(0, 47)] ^= 1'b1;
            1: pc[1:0] ^= 2'($urandom_range(1, 3));
            default: ;
         endcase
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               thr, pc, $urandom_range(0, 15) == 0);
      end
      idle(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
